// File: rtl/irq_timer_if.sv
// Bus-side interface of the interrupt timer: word-addressed register port and interrupt line.
interface irq_timer_if;
   logic [3:2]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   modport master (
      output addr,
      output we,
      output wdata,
      input  rdata,
      input  irq
   );

   modport slave (
      input  addr,
      input  we,
      input  wdata,
      output rdata,
      output irq
   );
endinterface

// File: rtl/irq_timer.sv
// Memory-mapped down-counter raising a CP0 hardware interrupt on expiry (one-shot or auto-reload).
// Optional feature macro: IRQ_TIMER_AUTORELOAD_EN enables the MODE field and auto-reload operation.
module irq_timer #(
   parameter logic [31:0] PRESET_INIT = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   irq_timer_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic        ctrl_en_r;
   logic [1:0]  ctrl_mode_r;
   logic        ctrl_im_r;
   logic [31:0] preset_r;
   logic [31:0] count_r;
   logic        irq_pending_r;
   logic        irq_r;

   logic        en_nxt_s;
   logic [1:0]  mode_nxt_s;
   logic        im_nxt_s;
   logic [31:0] preset_nxt_s;
   logic [31:0] count_nxt_s;
   logic        pending_nxt_s;
   logic        reload_s;
   logic [31:0] rdata_s;

`ifdef IRQ_TIMER_AUTORELOAD_EN
   assign reload_s = (ctrl_mode_r == 2'b01);
`else
   assign reload_s = 1'b0;
`endif

   // Next-state logic: FSM first, then bus writes so a CTRL/PRESET write overrides the FSM on the same edge.
   always_comb begin
      state_nxt_s   = state_r;
      en_nxt_s      = ctrl_en_r;
      mode_nxt_s    = ctrl_mode_r;
      im_nxt_s      = ctrl_im_r;
      preset_nxt_s  = preset_r;
      count_nxt_s   = count_r;
      pending_nxt_s = irq_pending_r;

      case (state_r)
         ST_IDLE: begin
            if (ctrl_en_r) begin
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            count_nxt_s = preset_r;
            state_nxt_s = ST_CNT;
         end
         ST_CNT: begin
            if (!ctrl_en_r) begin
               state_nxt_s = ST_IDLE;
            end else if (count_r > 32'd1) begin
               count_nxt_s = count_r - 32'd1;
            end else begin
               count_nxt_s   = 32'd0;
               pending_nxt_s = 1'b1;
               state_nxt_s   = ST_INT;
               // One-shot expiry disarms the timer; auto-reload keeps it running.
               if (reload_s) begin
                  en_nxt_s = 1'b1;
               end else begin
                  en_nxt_s = 1'b0;
               end
            end
         end
         ST_INT: begin
`ifdef IRQ_TIMER_AUTORELOAD_EN
            if (reload_s && ctrl_en_r) begin
               pending_nxt_s = 1'b0;
               state_nxt_s   = ST_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
`else
            state_nxt_s = ST_IDLE;
`endif
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase

      case ({bus.we, bus.addr})
         3'b100: begin
            en_nxt_s      = bus.wdata[0];
`ifdef IRQ_TIMER_AUTORELOAD_EN
            mode_nxt_s    = bus.wdata[2:1];
`endif
            im_nxt_s      = bus.wdata[3];
            pending_nxt_s = 1'b0;
         end
         3'b101: begin
            preset_nxt_s  = bus.wdata;
            pending_nxt_s = 1'b0;
         end
         default: begin
            pending_nxt_s = pending_nxt_s;
         end
      endcase
   end

   // State and register update; irq is registered from the next-state values so it has no bus-to-output path.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         ctrl_en_r     <= 1'b0;
         ctrl_mode_r   <= 2'b00;
         ctrl_im_r     <= 1'b0;
         preset_r      <= PRESET_INIT;
         count_r       <= 32'd0;
         irq_pending_r <= 1'b0;
         irq_r         <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         ctrl_en_r     <= en_nxt_s;
         ctrl_mode_r   <= mode_nxt_s;
         ctrl_im_r     <= im_nxt_s;
         preset_r      <= preset_nxt_s;
         count_r       <= count_nxt_s;
         irq_pending_r <= pending_nxt_s;
         irq_r         <= pending_nxt_s & im_nxt_s;
      end
   end

   // Read mux over the register map.
   always_comb begin
      rdata_s = 32'd0;
      case (bus.addr)
         2'd0:    rdata_s = {28'd0, ctrl_im_r, ctrl_mode_r, ctrl_en_r};
         2'd1:    rdata_s = preset_r;
         2'd2:    rdata_s = count_r;
         default: rdata_s = 32'd0;
      endcase
   end

   assign bus.rdata = rdata_s;
   assign bus.irq   = irq_r;

endmodule

// File: tb/tb_irq_timer.sv
// Directed self-checking bench for irq_timer; expected values are hand-derived cycle by cycle.
module tb_irq_timer;

   localparam logic [31:0] INIT = 32'hA5A5_0000;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   irq_timer_if bus ();

   irq_timer #(.PRESET_INIT(INIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance n rising edges and settle 1 time unit after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Single-cycle bus write; the write edge is the next rising edge.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.we    = 1'b1;
      bus.addr  = a;
      bus.wdata = d;
      @(posedge clk);
      #1;
      bus.we    = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
      bus.addr = a;
      #1;
      check(tag, bus.rdata, exp);
   endtask

   task automatic chk_irq(input string tag, input logic exp);
      check(tag, {31'd0, bus.irq}, {31'd0, exp});
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      reset     = 1'b1;
      bus.we    = 1'b0;
      bus.addr  = 2'd0;
      bus.wdata = 32'd0;
      tick(2);
      reset = 1'b0;

      // Reset state
      rd("rst_ctrl", 2'd0, 32'd0);
      rd("rst_preset", 2'd1, INIT);
      rd("rst_count", 2'd2, 32'd0);
      tick(1);
      rd("rst_unmapped", 2'd3, 32'd0);
      chk_irq("rst_irq", 1'b0);

      // One-shot, PRESET=5: irq rises at edge t7
      wr(2'd1, 32'd5);
      rd("os_preset", 2'd1, 32'd5);
      wr(2'd0, 32'h9);                       // t0
      tick(2);                               // t2
      rd("os_count_t2", 2'd2, 32'd5);
      chk_irq("os_irq_t2", 1'b0);
      tick(4);                               // t6
      rd("os_count_t6", 2'd2, 32'd1);
      chk_irq("os_irq_t6", 1'b0);
      tick(1);                               // t7
      chk_irq("os_irq_t7", 1'b1);
      rd("os_ctrl_t7", 2'd0, 32'h8);
      rd("os_count_t7", 2'd2, 32'd0);
      tick(3);
      chk_irq("os_irq_held", 1'b1);
      wr(2'd0, 32'd0);
      chk_irq("os_irq_cleared", 1'b0);
      tick(2);
      chk_irq("os_irq_stays_low", 1'b0);

      // Auto-reload request, PRESET=3, CTRL=0xB
      wr(2'd1, 32'd3);
      wr(2'd0, 32'hB);                       // t0
      tick(2);                               // t2
      rd("ar_count_t2", 2'd2, 32'd3);
      tick(2);                               // t4
      rd("ar_count_t4", 2'd2, 32'd1);
      chk_irq("ar_irq_t4", 1'b0);
      tick(1);                               // t5
      chk_irq("ar_irq_t5", 1'b1);
      rd("ar_count_t5", 2'd2, 32'd0);
`ifdef IRQ_TIMER_AUTORELOAD_EN
      tick(1);                               // t6
      chk_irq("ar_irq_t6", 1'b0);
      tick(1);                               // t7
      rd("ar_count_t7", 2'd2, 32'd3);
      chk_irq("ar_irq_t7", 1'b0);
      tick(2);                               // t9
      chk_irq("ar_irq_t9", 1'b0);
      tick(1);                               // t10
      chk_irq("ar_irq_t10", 1'b1);
      rd("ar_ctrl", 2'd0, 32'hB);
      tick(1);                               // t11
      chk_irq("ar_irq_t11", 1'b0);
      tick(4);                               // t15
      chk_irq("ar_irq_t15", 1'b1);
`else
      tick(2);                               // t7
      chk_irq("os2_irq_t7", 1'b1);
      rd("os2_count_t7", 2'd2, 32'd0);
      tick(3);                               // t10
      chk_irq("os2_irq_t10", 1'b1);
      rd("os2_ctrl", 2'd0, 32'h8);
`endif
      wr(2'd0, 32'd0);
      tick(3);
      chk_irq("ar_stop_irq", 1'b0);

      // Masked expiry, PRESET=10, CTRL=EN only
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h1);                       // t0
      tick(12);                              // t12
      rd("mask_count", 2'd2, 32'd0);
      rd("mask_ctrl", 2'd0, 32'd0);
      chk_irq("mask_irq", 1'b0);
      wr(2'd0, 32'h8);
      chk_irq("mask_unmask_irq", 1'b0);
      tick(2);
      chk_irq("mask_unmask_irq_later", 1'b0);
      wr(2'd0, 32'd0);

      // Disable mid-count: CTRL=0 written on the edge that makes COUNT 4
      wr(2'd0, 32'h9);                       // t0, PRESET still 10
      tick(7);                               // t7
      rd("dis_count_t7", 2'd2, 32'd5);
      wr(2'd0, 32'd0);                       // t8
      rd("dis_count_t8", 2'd2, 32'd4);
      tick(3);
      rd("dis_count_hold", 2'd2, 32'd4);
      rd("dis_ctrl", 2'd0, 32'd0);
      chk_irq("dis_irq", 1'b0);

      // Reset mid-count, with a simultaneous write that must be ignored
      wr(2'd1, 32'd7);
      wr(2'd0, 32'h9);                       // t0
      tick(3);                               // t3
      rd("mid_count_t3", 2'd2, 32'd6);
      reset     = 1'b1;
      bus.we    = 1'b1;
      bus.addr  = 2'd0;
      bus.wdata = 32'hF;
      @(posedge clk);
      #1;
      reset  = 1'b0;
      bus.we = 1'b0;
      rd("mrst_ctrl", 2'd0, 32'd0);
      rd("mrst_preset", 2'd1, INIT);
      rd("mrst_count", 2'd2, 32'd0);
      chk_irq("mrst_irq", 1'b0);
      tick(10);
      rd("mrst_count_idle", 2'd2, 32'd0);
      chk_irq("mrst_irq_idle", 1'b0);

      // PRESET=0: irq at edge t3; COUNT ignores writes
      wr(2'd1, 32'd0);
      rd("z_preset", 2'd1, 32'd0);
      wr(2'd0, 32'h9);                       // t0
      tick(2);                               // t2
      chk_irq("z_irq_t2", 1'b0);
      tick(1);                               // t3
      chk_irq("z_irq_t3", 1'b1);
      wr(2'd2, 32'h1234);
      rd("z_count_ro", 2'd2, 32'd0);
      chk_irq("z_irq_after_count_wr", 1'b1);
      wr(2'd0, 32'd0);
      chk_irq("z_irq_cleared", 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
